// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES permutations, S-box tables and engine constants
// Bit numbering follows DES: vector MSB is DES bit 1.
package des_pkg;

  localparam int DES_BLK_W    = 64;
  localparam int DES_SUBKEY_W = 48;
  localparam int DES_ROUNDS   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } des_state_e;

  localparam int P_TAB [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };

  // Row r of box s is entry 4*s+r; column c is the nibble at [63-4c -: 4].
  localparam logic [63:0] SBOX_ROWS [32] = '{
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
  };

  function automatic logic [63:0] des_ip(input logic [63:0] x);
    logic [63:0] y;
    int src;
    for (int i = 0; i < 64; i++) begin
      src = (i / 8 < 4) ? (58 + 2 * (i / 8) - 8 * (i % 8))
                        : (57 + 2 * (i / 8 - 4) - 8 * (i % 8));
      y[63-i] = x[64-src];
    end
    return y;
  endfunction

  function automatic logic [63:0] des_fp(input logic [63:0] x);
    logic [63:0] y;
    int src;
    for (int i = 0; i < 64; i++) begin
      src = ((i % 8) % 2 == 0) ? (40 - i / 8 + 8 * ((i % 8) / 2))
                               : (8 - i / 8 + 8 * ((i % 8) / 2));
      y[63-i] = x[64-src];
    end
    return y;
  endfunction

  function automatic logic [47:0] des_e(input logic [31:0] x);
    logic [47:0] y;
    int src;
    for (int j = 0; j < 48; j++) begin
      src = ((4 * (j / 6) + (j % 6) - 1 + 32) % 32) + 1;
      y[47-j] = x[32-src];
    end
    return y;
  endfunction

  function automatic logic [31:0] des_p(input logic [31:0] x);
    logic [31:0] y;
    for (int i = 0; i < 32; i++) begin
      y[31-i] = x[32-P_TAB[i]];
    end
    return y;
  endfunction

  function automatic logic [3:0] des_sbox(input int box, input logic [5:0] b);
    logic [63:0] row_bits;
    logic [3:0]  col;
    row_bits = SBOX_ROWS[box * 4 + int'({b[5], b[0]})];
    col      = b[4:1];
    return row_bits[63 - 4 * int'(col) -: 4];
  endfunction

endpackage

// File: rtl/des_round_engine_f.sv
// rtl/des_round_engine_f.sv - combinational DES f-function: P(S(E(R) ^ K))
module des_f
  import des_pkg::*;
(
  input  logic [31:0] r_i,
  input  logic [47:0] k_i,
  output logic [31:0] f_o
);

  logic [47:0] mixed;
  logic [31:0] s_out;

  always_comb begin
    mixed = des_e(r_i) ^ k_i;
    s_out = '0;
    for (int s = 0; s < 8; s++) begin
      s_out[31 - 4 * s -: 4] = des_sbox(s, mixed[47 - 6 * s -: 6]);
    end
    f_o = des_p(s_out);
  end

endmodule

// File: rtl/des_round_engine.sv
// rtl/des_round_engine.sv - iterative 16-round DES datapath, one round per clock
// DES_ENGINE_KEY_LATCH_EN: capture round_keys at accept so rounds use a private copy.
module des_round_engine
  import des_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DES_SUBKEY_W*16-1:0]   round_keys,
  input  logic                         key_ready,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DES_BLK_W-1:0]         data_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DES_BLK_W-1:0]         data_out,
  output logic                         busy
);

  des_state_e state_q, state_d;
  logic [3:0]  rnd_q, rnd_d;
  logic [31:0] l_q, l_d, r_q, r_d;
  logic [63:0] dout_q, dout_d;
  logic [47:0] key_sel;
  logic [31:0] f_out;
  logic [DES_SUBKEY_W*16-1:0] key_src;

`ifdef DES_ENGINE_KEY_LATCH_EN
  logic [DES_SUBKEY_W*16-1:0] keys_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      keys_q <= '0;
    end else if (state_q == IDLE && in_valid && in_ready) begin
      keys_q <= round_keys;
    end
  end

  assign key_src = keys_q;
`else
  assign key_src = round_keys;
`endif

  // rnd_q counts rounds from 0, so round rnd_q+1 takes slice [767-48*rnd_q -: 48].
  assign key_sel = key_src[767 - 48 * int'(rnd_q) -: 48];

  des_f u_f (
    .r_i (r_q),
    .k_i (key_sel),
    .f_o (f_out)
  );

  assign in_ready  = (state_q == IDLE) && key_ready && !rst;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign data_out  = dout_q;

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    l_d     = l_q;
    r_d     = r_q;
    dout_d  = dout_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          {l_d, r_d} = des_ip(data_in);
          rnd_d      = 4'd0;
          state_d    = RUN;
        end
      end
      RUN: begin
        l_d   = r_q;
        r_d   = l_q ^ f_out;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == 4'd15) begin
          // Last round skips the swap: output is FP({R16, L16}).
          dout_d  = des_fp({r_d, l_d});
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rnd_q   <= 4'd0;
      l_q     <= '0;
      r_q     <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      l_q     <= l_d;
      r_q     <= r_d;
      dout_q  <= dout_d;
    end
  end

endmodule

// File: tb/tb_des_round_engine.sv
// tb/tb_des_round_engine.sv - self-checking bench for des_round_engine
// Reference DES is table driven with its own key schedule.
module tb_des_round_engine;

  logic         clk = 1'b0;
  logic         rst;
  logic [767:0] round_keys;
  logic         key_ready;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  data_in;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  data_out;
  logic         busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  des_round_engine dut (
    .clk        (clk),
    .rst        (rst),
    .round_keys (round_keys),
    .key_ready  (key_ready),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_in    (data_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .data_out   (data_out),
    .busy       (busy)
  );

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7
  };
  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
    12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
    22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
  };
  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10, 23, 19, 12,  4,
    26,  8, 16,  7, 27, 20, 13,  2, 41, 52, 31, 37, 47, 55, 30, 40,
    51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SHIFT_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam logic [63:0] SB [32] = '{
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
  };

  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT  = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT  = 64'h85E813540F0AB405;
  localparam logic [63:0] ZCT = 64'h8CA64DE9C1B123A7;

  function automatic logic [31:0] m_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s, y;
    logic [5:0]  b;
    logic [63:0] row;
    for (int j = 0; j < 48; j++) x[47-j] = r[32-E_T[j]];
    x = x ^ k;
    for (int i = 0; i < 8; i++) begin
      b   = x[47 - 6 * i -: 6];
      row = SB[4 * i + 2 * int'(b[5]) + int'(b[0])];
      s[31 - 4 * i -: 4] = row[63 - 4 * int'(b[4:1]) -: 4];
    end
    for (int j = 0; j < 32; j++) y[31-j] = s[32-P_T[j]];
    return y;
  endfunction

  function automatic logic [767:0] m_bundle(input logic [63:0] key, input bit decrypt);
    logic [55:0]  cd;
    logic [27:0]  c, d;
    logic [47:0]  sub;
    logic [767:0] ks;
    int slot;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int n = 0; n < 16; n++) begin
      for (int s = 0; s < SHIFT_T[n]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int j = 0; j < 48; j++) sub[47-j] = cd[56-PC2_T[j]];
      slot = decrypt ? 15 - n : n;
      ks[767 - 48 * slot -: 48] = sub;
    end
    return ks;
  endfunction

  function automatic logic [63:0] m_des(input logic [767:0] ks, input logic [63:0] din);
    logic [63:0] t, y;
    logic [31:0] l, r, tmp;
    for (int i = 0; i < 64; i++) t[63-i] = din[64-IP_T[i]];
    l = t[63:32];
    r = t[31:0];
    for (int n = 0; n < 16; n++) begin
      tmp = r;
      r   = l ^ m_f(r, ks[767 - 48 * n -: 48]);
      l   = tmp;
    end
    t = {r, l};
    for (int i = 0; i < 64; i++) y[64-IP_T[i]] = t[63-i];
    return y;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready && n < 40) begin
      cyc();
      n++;
    end
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  task automatic wait_out(input string tag, output int n);
    n = 0;
    while (!out_valid && n < 40) begin
`ifdef DES_ENGINE_KEY_LATCH_EN
      round_keys = {24{$urandom}};
`endif
      cyc();
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'd16);
  endtask

  task automatic run_block(input logic [767:0] ks, input logic [63:0] din,
                           input logic [63:0] exp, input string tag);
    int n;
    round_keys = ks;
    data_in    = din;
    key_ready  = 1'b1;
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    wait_ready(tag);
    cyc();
    in_valid = 1'b0;
    wait_out(tag, n);
    chk({tag, "_data"}, data_out, exp);
    cyc();
    chk({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    round_keys = ks;
  endtask

  initial begin
    logic [767:0] ke, kd, kz, ks;
    logic [63:0]  key, din;
    logic         stable;
    bit           seen;
    int           n;

    ke = m_bundle(KEY, 1'b0);
    kd = m_bundle(KEY, 1'b1);
    kz = m_bundle(64'd0, 1'b0);

    rst        = 1'b1;
    key_ready  = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    data_in    = '0;
    round_keys = '0;
    cyc();
    cyc();
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_data_out", data_out, 64'd0);
    key_ready = 1'b1;
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'd0);

    rst       = 1'b0;
    key_ready = 1'b0;
    in_valid  = 1'b1;
    #1;
    chk("no_key_in_ready", 64'(in_ready), 64'd0);
    cyc();
    chk("no_key_busy", 64'(busy), 64'd0);
    in_valid = 1'b0;

    run_block(ke, PT, CT, "kv_enc");
    run_block(kd, CT, PT, "kv_dec");
    run_block(kz, 64'd0, ZCT, "kv_zero");

    // Backpressure, then minimum initiation interval with in_valid held high.
    round_keys = ke;
    data_in    = PT;
    key_ready  = 1'b1;
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    wait_ready("bp");
    cyc();
    in_valid = 1'b0;
    wait_out("bp", n);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (data_out !== CT || in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b1)
        stable = 1'b0;
    end
    chk("bp_hold", 64'(stable), 64'd1);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    cyc();
    chk("bp_release_valid", 64'(out_valid), 64'd0);
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    cyc();
    n = 0;
    do begin
      cyc();
      n++;
    end while (!in_ready && n < 40);
    chk("min_ii", 64'(n + 1), 64'd18);
    chk("min_ii_data", data_out, CT);
    cyc();
    in_valid = 1'b0;
    wait_out("ii2", n);
    chk("ii2_data", data_out, CT);
    cyc();

    // Reset after eight rounds aborts the block.
    in_valid = 1'b1;
    wait_ready("abort");
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) cyc();
    rst = 1'b1;
    cyc();
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_data_out", data_out, 64'd0);
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_output", 64'(seen), 64'd0);
    run_block(ke, PT, CT, "post_reset");

    for (int i = 0; i < 6; i++) begin
      key = {$urandom, $urandom};
      din = {$urandom, $urandom};
      ks  = m_bundle(key, i[0]);
      run_block(ks, din, m_des(ks, din), $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
